// File: rtl/gray_code_counter_8_bit.sv
// Up/down counter with registered binary and Gray outputs that always change together.
// Gray-coded parallel load, optional saturation at the ends, and a one-cycle wrap pulse.
module gray_code_counter_8_bit #(
   parameter int WIDTH    = 8,
   parameter int SATURATE = 0
) (
   input  logic             Clk_In,
   input  logic             Reset_N_In,
   input  logic             Clear_In,
   input  logic             Load_In,
   input  logic [WIDTH-1:0] Load_Gray_Data_In,
   input  logic             Enable_In,
   input  logic             Up_Down_In,
   output logic [WIDTH-1:0] Binary_Count_Out,
   output logic [WIDTH-1:0] Gray_Count_Out,
   output logic             Terminal_Count_Out,
   output logic             Wrap_Pulse_Out
);

   logic [WIDTH-1:0] binary_q;
   logic [WIDTH-1:0] gray_q;
   logic             wrap_q;
   logic [WIDTH-1:0] load_binary;
   logic [WIDTH-1:0] next_binary;
   logic [WIDTH-1:0] next_gray;
   logic             at_max;
   logic             at_min;
   logic             at_end;

   // Gray-to-binary: binary bit i is the XOR of all Gray bits from i upward.
   always_comb begin
      load_binary = '0;
      for (int i = 0; i < WIDTH; i++) begin
         load_binary[i] = ^(Load_Gray_Data_In >> i);
      end
   end

   always_comb begin
      at_max      = &binary_q;
      at_min      = ~|binary_q;
      at_end      = Up_Down_In ? at_max : at_min;
      next_binary = Up_Down_In ? (binary_q + WIDTH'(1)) : (binary_q - WIDTH'(1));
      next_gray   = next_binary ^ (next_binary >> 1);
   end

   always_ff @(posedge Clk_In or negedge Reset_N_In) begin
      if (!Reset_N_In) begin
         binary_q <= '0;
         gray_q   <= '0;
         wrap_q   <= 1'b0;
      end else if (Clear_In) begin
         binary_q <= '0;
         gray_q   <= '0;
         wrap_q   <= 1'b0;
      end else if (Load_In) begin
         binary_q <= load_binary;
         gray_q   <= Load_Gray_Data_In;
         wrap_q   <= 1'b0;
      end else if (Enable_In) begin
         // In saturate mode a step past either end is simply dropped.
         if (at_end && (SATURATE != 0)) begin
            wrap_q <= 1'b0;
         end else begin
            binary_q <= next_binary;
            gray_q   <= next_gray;
            wrap_q   <= at_end;
         end
      end else begin
         wrap_q <= 1'b0;
      end
   end

   assign Binary_Count_Out   = binary_q;
   assign Gray_Count_Out     = gray_q;
   assign Wrap_Pulse_Out     = wrap_q;
   assign Terminal_Count_Out = at_end;

endmodule

// File: tb/tb_gray_code_counter_8_bit.sv
// Directed bench: a wrapping and a saturating instance share stimulus; each task checks its own feature.
module tb_gray_code_counter_8_bit;

   logic       clk;
   logic       rst_n;
   logic       clear;
   logic       load;
   logic [7:0] load_data;
   logic       enable;
   logic       up;
   logic [7:0] bin0, gray0, bin1, gray1;
   logic       tc0, wrap0, tc1, wrap1;
   int         checks;
   int         failures;

   gray_code_counter_8_bit #(.WIDTH(8), .SATURATE(0)) dut_wrap (
      .Clk_In(clk), .Reset_N_In(rst_n), .Clear_In(clear), .Load_In(load),
      .Load_Gray_Data_In(load_data), .Enable_In(enable), .Up_Down_In(up),
      .Binary_Count_Out(bin0), .Gray_Count_Out(gray0),
      .Terminal_Count_Out(tc0), .Wrap_Pulse_Out(wrap0)
   );

   gray_code_counter_8_bit #(.WIDTH(8), .SATURATE(1)) dut_sat (
      .Clk_In(clk), .Reset_N_In(rst_n), .Clear_In(clear), .Load_In(load),
      .Load_Gray_Data_In(load_data), .Enable_In(enable), .Up_Down_In(up),
      .Binary_Count_Out(bin1), .Gray_Count_Out(gray1),
      .Terminal_Count_Out(tc1), .Wrap_Pulse_Out(wrap1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; up = 1'b1;
      #2;
      checks++; if (bin0 !== 8'h00) begin failures++; $display("[TB] FAIL reset_bin got=%h exp=00", bin0); end
      checks++; if (gray0 !== 8'h00) begin failures++; $display("[TB] FAIL reset_gray got=%h exp=00", gray0); end
      checks++; if (wrap0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_wrap got=%b exp=0", wrap0); end
      checks++; if (tc0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_tc_up got=%b exp=0", tc0); end
      up = 1'b0;
      #1;
      checks++; if (tc0 !== 1'b1) begin failures++; $display("[TB] FAIL reset_tc_down got=%b exp=1", tc0); end
      up = 1'b1;
      @(negedge clk) rst_n = 1'b1;
      // Load 0x5A (Gray 0x77) with enable also high: the load wins.
      load = 1'b1; load_data = 8'h77; enable = 1'b1;
      tick();
      load = 1'b0;
      checks++; if (bin0 !== 8'h5A) begin failures++; $display("[TB] FAIL load_5a_bin got=%h exp=5a", bin0); end
      checks++; if (gray0 !== 8'h77) begin failures++; $display("[TB] FAIL load_5a_gray got=%h exp=77", gray0); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bin0 !== 8'h00) begin failures++; $display("[TB] FAIL midreset_bin got=%h exp=00", bin0); end
      checks++; if (gray0 !== 8'h00) begin failures++; $display("[TB] FAIL midreset_gray got=%h exp=00", gray0); end
      checks++; if (wrap0 !== 1'b0) begin failures++; $display("[TB] FAIL midreset_wrap got=%b exp=0", wrap0); end
      checks++; if (tc0 !== 1'b0) begin failures++; $display("[TB] FAIL midreset_tc got=%b exp=0", tc0); end
      tick();
      checks++; if (bin0 !== 8'h00) begin failures++; $display("[TB] FAIL reset_held_bin got=%h exp=00", bin0); end
      @(negedge clk) rst_n = 1'b1; up = 1'b0;
      tick();
      enable = 1'b0;
      checks++; if (bin0 !== 8'hFF) begin failures++; $display("[TB] FAIL release_down_bin got=%h exp=ff", bin0); end
      checks++; if (gray0 !== 8'h80) begin failures++; $display("[TB] FAIL release_down_gray got=%h exp=80", gray0); end
      checks++; if (wrap0 !== 1'b1) begin failures++; $display("[TB] FAIL release_down_wrap got=%b exp=1", wrap0); end
      checks++; if (bin1 !== 8'h00) begin failures++; $display("[TB] FAIL release_sat_bin got=%h exp=00", bin1); end
      checks++; if (wrap1 !== 1'b0) begin failures++; $display("[TB] FAIL release_sat_wrap got=%b exp=0", wrap1); end
   endtask

   task automatic test_load();
      up = 1'b1; load = 1'b1; load_data = 8'h80;
      tick();
      checks++; if (bin0 !== 8'hFF) begin failures++; $display("[TB] FAIL load80_bin got=%h exp=ff", bin0); end
      checks++; if (gray0 !== 8'h80) begin failures++; $display("[TB] FAIL load80_gray got=%h exp=80", gray0); end
      checks++; if (wrap0 !== 1'b0) begin failures++; $display("[TB] FAIL load80_wrap got=%b exp=0", wrap0); end
      checks++; if (tc0 !== 1'b1) begin failures++; $display("[TB] FAIL load80_tc got=%b exp=1", tc0); end
      load_data = 8'hC0;
      tick();
      load = 1'b0;
      checks++; if (bin0 !== 8'h80) begin failures++; $display("[TB] FAIL loadc0_bin got=%h exp=80", bin0); end
      checks++; if (tc0 !== 1'b0) begin failures++; $display("[TB] FAIL loadc0_tc got=%b exp=0", tc0); end
   endtask

   task automatic test_up_wrap();
      load = 1'b1; load_data = 8'h80; up = 1'b1;
      tick();
      load = 1'b0;
      checks++; if (tc0 !== 1'b1) begin failures++; $display("[TB] FAIL upwrap_tc_before got=%b exp=1", tc0); end
      enable = 1'b1;
      tick();
      enable = 1'b0;
      checks++; if (bin0 !== 8'h00) begin failures++; $display("[TB] FAIL upwrap_bin got=%h exp=00", bin0); end
      checks++; if (gray0 !== 8'h00) begin failures++; $display("[TB] FAIL upwrap_gray got=%h exp=00", gray0); end
      checks++; if (wrap0 !== 1'b1) begin failures++; $display("[TB] FAIL upwrap_pulse got=%b exp=1", wrap0); end
      tick();
      checks++; if (wrap0 !== 1'b0) begin failures++; $display("[TB] FAIL upwrap_pulse_end got=%b exp=0", wrap0); end
      checks++; if (bin0 !== 8'h00) begin failures++; $display("[TB] FAIL upwrap_hold_bin got=%h exp=00", bin0); end
   endtask

   task automatic test_gray_walk();
      logic [7:0] prev_b, prev_g, exp_b;
      load = 1'b1; load_data = 8'h40;
      tick();
      load = 1'b0;
      checks++; if (bin0 !== 8'h7F) begin failures++; $display("[TB] FAIL walk_start_bin got=%h exp=7f", bin0); end
      up = 1'b1; enable = 1'b1;
      tick();
      checks++; if (bin0 !== 8'h80) begin failures++; $display("[TB] FAIL walk_first_bin got=%h exp=80", bin0); end
      checks++; if (gray0 !== 8'hC0) begin failures++; $display("[TB] FAIL walk_first_gray got=%h exp=c0", gray0); end
      for (int dir = 0; dir < 2; dir++) begin
         up = (dir == 0);
         for (int n = 0; n < 512; n++) begin
            prev_b = bin0; prev_g = gray0;
            exp_b  = up ? prev_b + 8'd1 : prev_b - 8'd1;
            tick();
            checks++; if (bin0 !== exp_b) begin failures++; $display("[TB] FAIL walk_bin got=%h exp=%h", bin0, exp_b); end
            checks++; if (gray0 !== (exp_b ^ (exp_b >> 1))) begin failures++; $display("[TB] FAIL walk_gray got=%h exp=%h", gray0, exp_b ^ (exp_b >> 1)); end
            checks++; if ($countones(gray0 ^ prev_g) != 1) begin failures++; $display("[TB] FAIL walk_onebit got=%h prev=%h", gray0, prev_g); end
            checks++; if (wrap0 !== (up ? (prev_b == 8'hFF) : (prev_b == 8'h00))) begin failures++; $display("[TB] FAIL walk_wrap got=%b prev=%h", wrap0, prev_b); end
         end
      end
      enable = 1'b0;
   endtask

   task automatic test_saturate();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checks++; if (bin1 !== 8'h00) begin failures++; $display("[TB] FAIL sat_clear_bin got=%h exp=00", bin1); end
      enable = 1'b1; up = 1'b0;
      for (int n = 0; n < 3; n++) begin
         tick();
         checks++; if (bin1 !== 8'h00) begin failures++; $display("[TB] FAIL sat_low_bin got=%h exp=00", bin1); end
         checks++; if (wrap1 !== 1'b0) begin failures++; $display("[TB] FAIL sat_low_wrap got=%b exp=0", wrap1); end
         checks++; if (tc1 !== 1'b1) begin failures++; $display("[TB] FAIL sat_low_tc got=%b exp=1", tc1); end
      end
      enable = 1'b0; load = 1'b1; load_data = 8'h80;
      tick();
      load = 1'b0; enable = 1'b1; up = 1'b1;
      for (int n = 0; n < 2; n++) begin
         tick();
         checks++; if (bin1 !== 8'hFF) begin failures++; $display("[TB] FAIL sat_high_bin got=%h exp=ff", bin1); end
         checks++; if (gray1 !== 8'h80) begin failures++; $display("[TB] FAIL sat_high_gray got=%h exp=80", gray1); end
         checks++; if (wrap1 !== 1'b0) begin failures++; $display("[TB] FAIL sat_high_wrap got=%b exp=0", wrap1); end
      end
      enable = 1'b0;
   endtask

   task automatic test_priority();
      load = 1'b1; load_data = 8'h2A;
      tick();
      checks++; if (bin0 !== 8'h33) begin failures++; $display("[TB] FAIL prio_setup_bin got=%h exp=33", bin0); end
      clear = 1'b1; load_data = 8'h80; enable = 1'b1; up = 1'b1;
      tick();
      clear = 1'b0;
      checks++; if (bin0 !== 8'h00) begin failures++; $display("[TB] FAIL prio_clear_bin got=%h exp=00", bin0); end
      checks++; if (gray0 !== 8'h00) begin failures++; $display("[TB] FAIL prio_clear_gray got=%h exp=00", gray0); end
      tick();
      load = 1'b0;
      checks++; if (bin0 !== 8'hFF) begin failures++; $display("[TB] FAIL prio_load_bin got=%h exp=ff", bin0); end
      checks++; if (gray0 !== 8'h80) begin failures++; $display("[TB] FAIL prio_load_gray got=%h exp=80", gray0); end
      checks++; if (wrap0 !== 1'b0) begin failures++; $display("[TB] FAIL prio_load_wrap got=%b exp=0", wrap0); end
      // Clear on an edge that would otherwise wrap must suppress the pulse.
      clear = 1'b1;
      tick();
      clear = 1'b0; enable = 1'b0;
      checks++; if (bin0 !== 8'h00) begin failures++; $display("[TB] FAIL prio_clearwrap_bin got=%h exp=00", bin0); end
      checks++; if (wrap0 !== 1'b0) begin failures++; $display("[TB] FAIL prio_clearwrap_pulse got=%b exp=0", wrap0); end
   endtask

   task automatic test_back_to_back();
      load = 1'b1; load_data = 8'h18;
      tick();
      load = 1'b0;
      for (int n = 0; n < 3; n++) begin
         tick();
         checks++; if (bin0 !== 8'h10) begin failures++; $display("[TB] FAIL hold_bin got=%h exp=10", bin0); end
         checks++; if (gray0 !== 8'h18) begin failures++; $display("[TB] FAIL hold_gray got=%h exp=18", gray0); end
      end
      enable = 1'b1; up = 1'b1;
      tick();
      checks++; if (gray0 !== 8'h19) begin failures++; $display("[TB] FAIL b2b_up1_gray got=%h exp=19", gray0); end
      tick();
      checks++; if (bin0 !== 8'h12) begin failures++; $display("[TB] FAIL b2b_up2_bin got=%h exp=12", bin0); end
      checks++; if (gray0 !== 8'h1B) begin failures++; $display("[TB] FAIL b2b_up2_gray got=%h exp=1b", gray0); end
      up = 1'b0;
      tick();
      enable = 1'b0;
      checks++; if (bin0 !== 8'h11) begin failures++; $display("[TB] FAIL b2b_down_bin got=%h exp=11", bin0); end
      checks++; if (gray0 !== 8'h19) begin failures++; $display("[TB] FAIL b2b_down_gray got=%h exp=19", gray0); end
   endtask

   initial begin
      checks = 0; failures = 0;
      rst_n = 1'b1; clear = 1'b0; load = 1'b0; load_data = 8'h00; enable = 1'b0; up = 1'b1;
      tick();
      test_reset();
      test_load();
      test_up_wrap();
      test_gray_walk();
      test_saturate();
      test_priority();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
